// File: rtl/sdram_refresh_ctrl_if.sv
// Arbiter-side handshake and command bus of the SDRAM auto-refresh engine.
// master: the refresh engine; slave: the SDRAM arbiter / command mux.
interface sdram_refresh_ctrl_if;
    logic       refreshRequest;
    logic       refreshGrant;
    logic       refreshUrgent;
    logic       refreshBusy;
    logic       refreshFinishFlag;
    logic [6:0] cmd;

    modport master (
        output refreshRequest,
        output refreshUrgent,
        output refreshBusy,
        output refreshFinishFlag,
        output cmd,
        input  refreshGrant
    );

    modport slave (
        input  refreshRequest,
        input  refreshUrgent,
        input  refreshBusy,
        input  refreshFinishFlag,
        input  cmd,
        output refreshGrant
    );
endinterface

// File: rtl/sdram_refresh_ctrl.sv
// SDRAM auto-refresh engine: refresh debt counter, grant handshake, PrechargeAll + burst AutoRefresh.
// Define SDRAM_REFRESH_OVERFLOW_EN to build the sticky debt-overflow flag; otherwise overflow is 0.
module sdram_refresh_ctrl #(
    parameter int REFRESH_INTERVAL = 7800,
    parameter int TRP              = 2,
    parameter int TRFC             = 7,
    parameter int MAX_POSTPONE     = 8,
    parameter int DEBT_W           = $clog2(MAX_POSTPONE + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    sdram_refresh_ctrl_if.master bus,
    output logic [DEBT_W-1:0]    debt,
    output logic                 dram_clk,
    output logic                 overflow
);

    localparam int CNT_W    = $clog2(REFRESH_INTERVAL);
    localparam int WAIT_MAX = (TRP > TRFC) ? TRP : TRFC;
    localparam int WAIT_W   = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [WAIT_W-1:0] TRP_LOAD    = WAIT_W'((TRP > 1) ? TRP - 2 : 0);
    localparam logic [WAIT_W-1:0] TRFC_LOAD   = WAIT_W'((TRFC > 1) ? TRFC - 2 : 0);
    localparam logic [DEBT_W-1:0] DEBT_MAX    = DEBT_W'(MAX_POSTPONE);
    localparam logic [DEBT_W-1:0] DEBT_URGENT = DEBT_W'(MAX_POSTPONE - 1);
    localparam logic [DEBT_W-1:0] DEBT_ONE    = DEBT_W'(1);

    localparam logic [6:0] CMD_NOP = 7'b1100000;
    localparam logic [6:0] CMD_PRE = 7'b1001000;
    localparam logic [6:0] CMD_REF = 7'b1000100;

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        TRP_WAIT,
        REFRESH,
        TRFC_WAIT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   interval_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [DEBT_W-1:0]  debt_q;
    logic [6:0]         cmd_q;
    logic [6:0]         state_cmd;
    logic               tick;
    logic               refresh_now;
    logic               request;
    logic               busy;
    logic               finish;

    assign tick        = enable && (interval_cnt == CNT_LAST);
    assign refresh_now = (state == REFRESH);

    // Interval counter: wraps at REFRESH_INTERVAL-1 and freezes while disabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            interval_cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                interval_cnt <= '0;
            end else begin
                interval_cnt <= interval_cnt + CNT_W'(1);
            end
        end
    end

    // A tick landing on the AutoRefresh cycle cancels the decrement, even when saturated.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            debt_q <= '0;
        end else if (tick && !refresh_now) begin
            if (debt_q != DEBT_MAX) begin
                debt_q <= debt_q + DEBT_ONE;
            end
        end else if (refresh_now && !tick) begin
            debt_q <= debt_q - DEBT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait windows are loaded on entry and count down to zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            if (state_nxt == TRP_WAIT) begin
                wait_cnt <= TRP_LOAD;
            end else begin
                wait_cnt <= TRFC_LOAD;
            end
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        state_cmd = CMD_NOP;
        request   = 1'b0;
        busy      = 1'b1;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                busy    = 1'b0;
                request = (debt_q != '0);
                if (bus.refreshGrant && (debt_q != '0)) begin
                    state_nxt = PRECHARGE;
                end
            end
            PRECHARGE: begin
                state_cmd = CMD_PRE;
                state_nxt = (TRP > 1) ? TRP_WAIT : REFRESH;
            end
            TRP_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = REFRESH;
                end
            end
            REFRESH: begin
                state_cmd = CMD_REF;
                // Without a tRFC window the continue decision uses the post-refresh debt.
                if (TRFC > 1) begin
                    state_nxt = TRFC_WAIT;
                end else if (bus.refreshGrant && (debt_q > DEBT_ONE)) begin
                    state_nxt = REFRESH;
                end else begin
                    state_nxt = DONE;
                end
            end
            TRFC_WAIT: begin
                if (wait_cnt == '0) begin
                    if (bus.refreshGrant && (debt_q != '0)) begin
                        state_nxt = REFRESH;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q <= CMD_NOP;
        end else begin
            cmd_q <= state_cmd;
        end
    end

`ifdef SDRAM_REFRESH_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (tick && (debt_q == DEBT_MAX)) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign bus.refreshRequest    = request;
    assign bus.refreshUrgent     = (debt_q >= DEBT_URGENT);
    assign bus.refreshBusy       = busy;
    assign bus.refreshFinishFlag = finish;
    assign bus.cmd               = cmd_q;
    assign debt                  = debt_q;
    assign dram_clk              = ~clock;

endmodule

// File: tb/tb_sdram_refresh_ctrl.sv
// Directed bench for sdram_refresh_ctrl with a session-position model of the refresh schedule.
module tb_sdram_refresh_ctrl;

    localparam int RI   = 20;
    localparam int TRP  = 2;
    localparam int TRFC = 4;
    localparam int MAXP = 4;
    localparam int DW   = $clog2(MAXP + 1);
`ifdef SDRAM_REFRESH_OVERFLOW_EN
    localparam int OVF_EN = 1;
`else
    localparam int OVF_EN = 0;
`endif
    localparam logic [6:0] C_NOP = 7'b1100000;
    localparam logic [6:0] C_PA  = 7'b1001000;
    localparam logic [6:0] C_AR  = 7'b1000100;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable  = 1'b0;
    logic [DW-1:0] debt;
    logic          dram_clk;
    logic          overflow;

    sdram_refresh_ctrl_if bus();

    sdram_refresh_ctrl #(
        .REFRESH_INTERVAL(RI),
        .TRP(TRP),
        .TRFC(TRFC),
        .MAX_POSTPONE(MAXP)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .bus(bus),
        .debt(debt),
        .dram_clk(dram_clk),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Model: a session is a timeline of positions; pos 0 is PrechargeAll, refreshes at m_ref,
    // each followed by a TRFC window whose last cycle decides between another refresh and the finish cycle.
    int         m_cnt  = 0;
    int         m_debt = 0;
    int         m_ovf  = 0;
    bit         m_sess = 1'b0;
    int         m_pos  = 0;
    int         m_ref  = 0;
    int         m_done = -1;
    logic [6:0] m_cmd  = C_NOP;
    bit         n_tick;
    bit         n_refr;
    int         n_left;

    always_comb begin
        n_tick = enable && (m_cnt == RI - 1);
        n_refr = m_sess && (m_pos == m_ref);
        n_left = m_debt - (n_refr ? 1 : 0);
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt  <= 0;
            m_debt <= 0;
            m_ovf  <= 0;
            m_sess <= 1'b0;
            m_pos  <= 0;
            m_ref  <= 0;
            m_done <= -1;
            m_cmd  <= C_NOP;
        end else begin
            m_cmd <= (m_sess && m_pos == 0) ? C_PA : (n_refr ? C_AR : C_NOP);
            m_cnt <= enable ? (m_cnt + 1) % RI : m_cnt;
            if (n_tick && m_debt == MAXP) m_ovf <= OVF_EN;
            if (n_tick && !n_refr) m_debt <= (m_debt < MAXP) ? m_debt + 1 : MAXP;
            else if (n_refr && !n_tick) m_debt <= m_debt - 1;
            if (!m_sess) begin
                if (bus.refreshGrant && m_debt > 0) begin
                    m_sess <= 1'b1;
                    m_pos  <= 0;
                    m_ref  <= TRP;
                    m_done <= -1;
                end
            end else if (m_pos == m_done) begin
                m_sess <= 1'b0;
            end else begin
                m_pos <= m_pos + 1;
                if (m_done < 0 && m_pos == m_ref + TRFC - 1) begin
                    if (bus.refreshGrant && n_left > 0) m_ref <= m_pos + 1;
                    else m_done <= m_pos + 1;
                end
            end
        end
    end

    int tests  = 0;
    int fails  = 0;
    int edge_n = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
        end
    endtask

    // One clock: past the rising edge, then compare every output against the model.
    task automatic step();
        @(negedge clock);
        #1;
        edge_n++;
        check("cmd", int'(bus.cmd), int'(m_cmd));
        check("debt", int'(debt), m_debt);
        check("busy", int'(bus.refreshBusy), int'(m_sess));
        check("finish", int'(bus.refreshFinishFlag), int'(m_sess && m_pos == m_done));
        check("request", int'(bus.refreshRequest), int'(!m_sess && m_debt != 0));
        check("urgent", int'(bus.refreshUrgent), int'(m_debt >= MAXP - 1));
        check("overflow", int'(overflow), m_ovf);
        check("dram_clk", int'(dram_clk), 1);
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic restart();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        edge_n  = 0;
    endtask

    logic [6:0] seq_b [8];
    int busy_n, fin_n, pa_n, ar_n;
    int ar_pos [3];

    initial begin
        seq_b = '{C_NOP, C_PA, C_NOP, C_AR, C_NOP, C_NOP, C_NOP, C_NOP};
        bus.refreshGrant = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_cmd", int'(bus.cmd), int'(C_NOP));
        check("rst_debt", int'(debt), 0);
        check("rst_busy", int'(bus.refreshBusy), 0);
        check("rst_request", int'(bus.refreshRequest), 0);
        check("rst_urgent", int'(bus.refreshUrgent), 0);
        check("rst_finish", int'(bus.refreshFinishFlag), 0);
        check("rst_overflow", int'(overflow), 0);
        @(negedge clock);
        reset_n = 1'b1;
        enable  = 1'b1;
        edge_n  = 0;

        // Debt accumulation and saturation with no grant.
        run_to(19); check("debt_before_tick", int'(debt), 0);
        run_to(20); check("debt_first_tick", int'(debt), 1);
        check("request_first_tick", int'(bus.refreshRequest), 1);
        run_to(59); check("urgent_at_2", int'(bus.refreshUrgent), 0);
        run_to(60); check("debt_3", int'(debt), 3);
        check("urgent_at_3", int'(bus.refreshUrgent), 1);
        run_to(80); check("debt_sat", int'(debt), 4);
        run_to(100); check("debt_hold_sat", int'(debt), 4);

        // Single refresh session from a one-cycle grant pulse.
        restart();
        run_to(20); check("b_debt_1", int'(debt), 1);
        busy_n = 0; fin_n = 0;
        bus.refreshGrant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            bus.refreshGrant = 1'b0;
            check($sformatf("b_seq%0d", i), int'(bus.cmd), int'(seq_b[i]));
            busy_n += int'(bus.refreshBusy);
            fin_n  += int'(bus.refreshFinishFlag);
        end
        check("b_busy_cycles", busy_n, 7);
        check("b_finish_pulses", fin_n, 1);
        check("b_debt_0", int'(debt), 0);

        // Burst of three refreshes under a held grant.
        run_to(80); check("c_debt_3", int'(debt), 3);
        pa_n = 0; ar_n = 0; fin_n = 0; ar_pos = '{0, 0, 0};
        bus.refreshGrant = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.cmd == C_PA) pa_n++;
            if (bus.cmd == C_AR) begin
                if (ar_n < 3) ar_pos[ar_n] = edge_n;
                ar_n++;
            end
            fin_n += int'(bus.refreshFinishFlag);
        end
        bus.refreshGrant = 1'b0;
        check("c_precharges", pa_n, 1);
        check("c_refreshes", ar_n, 3);
        check("c_first_ar_edge", ar_pos[0], 84);
        check("c_ar_gap1", ar_pos[1] - ar_pos[0], 4);
        check("c_ar_gap2", ar_pos[2] - ar_pos[1], 4);
        check("c_finish_pulses", fin_n, 1);
        check("c_debt_0", int'(debt), 0);
        check("c_idle_grant_no_debt", int'(bus.refreshBusy), 0);

        // Tick on the AutoRefresh cycle at debt 2.
        run_to(120); check("d_debt_2", int'(debt), 2);
        run_to(136);
        bus.refreshGrant = 1'b1;
        step();
        bus.refreshGrant = 1'b0;
        run_to(140);
        check("d_ar_on_tick", int'(bus.cmd), int'(C_AR));
        check("d_debt_unchanged", int'(debt), 2);
        run_to(145);

        // Asynchronous reset inside the tRFC window.
        run_to(150);
        bus.refreshGrant = 1'b1;
        step();
        bus.refreshGrant = 1'b0;
        run_to(154);
        check("e_ar_before_reset", int'(bus.cmd), int'(C_AR));
        check("e_debt_before_reset", int'(debt), 1);
        #1 reset_n = 1'b0;
        #1;
        check("e_rst_cmd", int'(bus.cmd), int'(C_NOP));
        check("e_rst_debt", int'(debt), 0);
        check("e_rst_busy", int'(bus.refreshBusy), 0);
        @(negedge clock);
        reset_n = 1'b1;
        edge_n  = 0;

        // Fifth tick at saturation, then a session with the interval counter frozen.
        run_to(99); check("f_ovf_before", int'(overflow), 0);
        run_to(100); check("f_ovf_after", int'(overflow), OVF_EN);
        bus.refreshGrant = 1'b1;
        enable = 1'b0;
        run_to(125);
        bus.refreshGrant = 1'b0;
        check("f_debt_drained", int'(debt), 0);
        check("f_ovf_sticky", int'(overflow), OVF_EN);
        run_to(160); check("f_debt_frozen", int'(debt), 0);
        enable = 1'b1;
        run_to(179); check("f_no_tick_yet", int'(debt), 0);
        run_to(180); check("f_tick_after_hold", int'(debt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
